clk_div_1p5: RTL and testbench



---
 rtl/clk_div_1p5.sv | 42 ++++
 tb/tb_clk_div_1p5.sv | 119 +++++++++++
 2 files changed

// File: rtl/clk_div_1p5.sv
// Divide-by-1.5 clock source: output period is three half-periods of clk,
// high for one half-period. Rising- and falling-edge mod-3 phases are ANDed.
module clk_div_1p5 (
    input  logic clk,
    input  logic rst,
    output logic clk_out
);

    logic [1:0] r_cnt_rise;
    logic [1:0] r_cnt_fall;
    logic       r_rst_q;
    logic       r_ph_rise;
    logic       r_ph_fall;

    // After rising edge R_n, r_ph_rise = (n mod 3 != 2); cleared in reset so clk_out drops at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_q    <= 1'b1;
            r_cnt_rise <= 2'd0;
            r_ph_rise  <= 1'b0;
        end else begin
            r_rst_q    <= 1'b0;
            r_cnt_rise <= (r_cnt_rise == 2'd2) ? 2'd0 : r_cnt_rise + 2'd1;
            r_ph_rise  <= (r_cnt_rise != 2'd2);
        end
    end

    // After falling edge F_n, r_ph_fall = (n mod 3 != 0); preset in reset so R0 can raise clk_out.
    always_ff @(negedge clk) begin
        if (r_rst_q) begin
            r_cnt_fall <= 2'd0;
            r_ph_fall  <= 1'b1;
        end else begin
            r_cnt_fall <= (r_cnt_fall == 2'd2) ? 2'd0 : r_cnt_fall + 2'd1;
            r_ph_fall  <= (r_cnt_fall != 2'd0);
        end
    end

    // Each clk edge moves at most one AND input, so the output cannot glitch.
    assign clk_out = r_ph_rise & r_ph_fall;

endmodule

// File: tb/tb_clk_div_1p5.sv
// Directed bench for clk_div_1p5: samples clk_out mid half-cycle against the
// hand-derived waveform and counts clk_out transitions to catch glitches.
`timescale 1ns/1ps
module tb_clk_div_1p5;

    logic clk;
    logic rst;
    logic clk_out;

    int n_vec;
    int n_err;
    int n_tr;
    int tr0;

    localparam real NEVER = 1.0e9;

    clk_div_1p5 dut (
        .clk     (clk),
        .rst     (rst),
        .clk_out (clk_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(clk_out) n_tr++;

    // Expected level: high during half-cycle k where k mod 3 == 0, k counted from R0.
    function automatic logic exp_at(real t, real r0);
        int k;
        if (t < r0) return 1'b0;
        k = int'($floor((t - r0) / 5.0));
        return (k % 3 == 0);
    endfunction

    task automatic chk(logic exp, string tag);
        n_vec++;
        assert (clk_out === exp)
        else begin
            n_err++;
            $error("FAIL %s t=%0t clk_out=%b expected=%b", tag, $time, clk_out, exp);
        end
    endtask

    task automatic chk_tr(int exp, string tag);
        n_vec++;
        assert ((n_tr - tr0) === exp)
        else begin
            n_err++;
            $error("FAIL %s t=%0t transitions=%0d expected=%0d", tag, $time, n_tr - tr0, exp);
        end
    endtask

    // Check every half-cycle midpoint up to t_end; stops on the last checked midpoint.
    task automatic run(real t_end, real r0, string tag);
        forever begin
            chk(exp_at($realtime, r0), tag);
            if ($realtime + 5.0 >= t_end) break;
            #5;
        end
    endtask

    // Drive rst at absolute time t, then realign to the next half-cycle midpoint.
    task automatic move_rst(real t, logic v);
        real nxt;
        #(t - $realtime);
        rst = v;
        nxt = 5.0 * $floor(($realtime - 2.5) / 5.0) + 7.5;
        #(nxt - $realtime);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        n_tr  = 0;
        rst   = 1'b1;
        #2.5;

        run(20.0, NEVER, "reset_hold");
        move_rst(20.0, 1'b0);

        tr0 = n_tr;
        run(340.0, 25.0, "steady");
        chk_tr(42, "steady_edges");

        run(362.0, 25.0, "pre_reassert");
        move_rst(362.0, 1'b1);
        run(382.0, NEVER, "reassert_low");
        move_rst(382.0, 1'b0);
        run(402.0, 385.0, "restart_r0");

        move_rst(402.0, 1'b1);
        chk(1'b1, "pulse_high_before");
        #5;
        chk(1'b0, "pulse_drop");
        move_rst(408.0, 1'b0);
        run(442.0, 415.0, "pulse_restart");

        move_rst(442.0, 1'b1);
        chk(1'b0, "pulse2_before");
        #5;
        chk(1'b0, "pulse2_suppress");
        move_rst(448.0, 1'b0);
        run(492.0, 455.0, "pulse2_restart");

        move_rst(492.0, 1'b1);
        tr0 = n_tr;
        run(1492.0, NEVER, "long_reset");
        chk_tr(0, "long_reset_edges");
        move_rst(1492.0, 1'b0);
        run(1560.0, 1495.0, "final_restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
